spi_frame_receiver: RTL and testbench

//   Front end of the SPI register path. Synchronises the raw SCLK/COPI/nCS pins into
//   clk, deserialises SPI mode-0 frames (MSB first), and presents each complete
//   {rw, addr, data} frame on a valid/ready interface.

---
 rtl/spi_frame_receiver.sv | 152 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 frame receiver: synchronises the SPI pins into clk, deserialises
// {rw, addr, data} frames MSB first and hands them out over valid/ready.
// Frames with a wrong bit count, and good frames that arrive while the previous
// one is still unaccepted, are flagged and never delivered.
module spi_frame_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              COPI,
  input  logic              nCS,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              frame_rw,
  output logic [ADDR_W-1:0] frame_addr,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned FRAME_BITS = 1 + ADDR_W + DATA_W;
  // Count must reach FRAME_BITS+1 so an over-long frame stays distinguishable.
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECV      = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_ff, copi_ff, ncs_ff;
  logic                   sclk_prev, ncs_prev;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise, ncs_fall;

  logic [FRAME_BITS-1:0]  shift_reg;
  logic [CNT_W-1:0]       bit_cnt;

  logic                   start_frame, shift_en, frame_good, frame_bad;

  // Equal-depth synchronisers keep SCLK, COPI and nCS aligned with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_ff   <= '0;
      copi_ff   <= '0;
      ncs_ff    <= '0;
      sclk_prev <= 1'b0;
      ncs_prev  <= 1'b0;
    end else begin
      sclk_ff   <= {sclk_ff[SYNC_STAGES-2:0], SCLK};
      copi_ff   <= {copi_ff[SYNC_STAGES-2:0], COPI};
      ncs_ff    <= {ncs_ff[SYNC_STAGES-2:0], nCS};
      sclk_prev <= sclk_ff[SYNC_STAGES-1];
      ncs_prev  <= ncs_ff[SYNC_STAGES-1];
    end
  end

  // Synchronised pin values and edge detects.
  always_comb begin
    sclk_s    = sclk_ff[SYNC_STAGES-1];
    copi_s    = copi_ff[SYNC_STAGES-1];
    ncs_s     = ncs_ff[SYNC_STAGES-1];
    sclk_rise = sclk_s & ~sclk_prev;
    ncs_rise  = ncs_s & ~ncs_prev;
    ncs_fall  = ~ncs_s & ncs_prev;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_next;
  end

  // Next state and per-cycle controls; an SCLK rise coinciding with nCS rise is dropped.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    frame_good  = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      WAIT_IDLE: begin
        if (ncs_s) state_next = IDLE;
      end
      IDLE: begin
        if (ncs_fall) begin
          state_next  = RECV;
          start_frame = 1'b1;
        end
      end
      RECV: begin
        if (ncs_rise) begin
          state_next = IDLE;
          if (bit_cnt == CNT_W'(FRAME_BITS)) frame_good = 1'b1;
          else if (bit_cnt != '0)            frame_bad  = 1'b1;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (start_frame) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_s};
      if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // Delivery, handshake, error pulse, sticky overrun and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid <= 1'b0;
      frame_rw    <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      busy      <= (state_next == RECV);
      if (frame_good) begin
        if (!frame_valid || frame_ready) begin
          frame_valid <= 1'b1;
          frame_rw    <= shift_reg[FRAME_BITS-1];
          frame_addr  <= shift_reg[FRAME_BITS-2 -: ADDR_W];
          frame_data  <= shift_reg[DATA_W-1:0];
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: drives SPI pins on the falling clk edge
// and checks outputs on the falling edge against hand-computed values.
module tb_spi_frame_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK, COPI, nCS;
  logic       frame_ready;
  logic       frame_valid, frame_rw, frame_err, overrun, busy;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  int total = 0;
  int bad   = 0;
  int err_cycles   = 0;
  int valid_cycles = 0;
  int err_base, valid_base;

  spi_frame_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .SCLK        (SCLK),
    .COPI        (COPI),
    .nCS         (nCS),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_rw    (frame_rw),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of the pulse outputs, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err)   err_cycles   <= err_cycles + 1;
    if (frame_valid) valid_cycles <= valid_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    nCS = 1'b0;
    tick(4);
  endtask

  // Shift n bits of val MSB first; COPI changes while SCLK is low (mode 0).
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      COPI = val[i];
      tick(4);
      SCLK = 1'b1;
      tick(4);
      SCLK = 1'b0;
    end
    tick(4);
  endtask

  task automatic chk_frame(input string tag, input logic rw, input logic [6:0] addr,
                           input logic [7:0] data);
    chk({tag, "_valid"}, 32'(frame_valid), 32'd1);
    chk({tag, "_rw"},    32'(frame_rw),    32'(rw));
    chk({tag, "_addr"},  32'(frame_addr),  32'(addr));
    chk({tag, "_data"},  32'(frame_data),  32'(data));
  endtask

  initial begin
    rst = 1'b1; SCLK = 1'b0; COPI = 1'b0; nCS = 1'b1; frame_ready = 1'b0;
    tick(3);
    chk("rst_valid",   32'(frame_valid), 32'd0);
    chk("rst_err",     32'(frame_err),   32'd0);
    chk("rst_overrun", 32'(overrun),     32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_fields",  32'({frame_rw, frame_addr, frame_data}), 32'd0);
    rst = 1'b0;
    tick(6);

    // Good frame, consumer ready: exact latency and a single valid cycle.
    frame_ready = 1'b1;
    err_base = err_cycles;
    frame_start();
    chk("busy_in_recv", 32'(busy), 32'd1);
    send_bits(32'h84F0, 16);
    nCS = 1'b1;
    tick(2);
    chk("lat_edge2_valid", 32'(frame_valid), 32'd0);
    tick(1);
    chk_frame("f84f0", 1'b1, 7'h04, 8'hF0);
    chk("f84f0_busy", 32'(busy), 32'd0);
    tick(1);
    chk("f84f0_one_cycle", 32'(frame_valid), 32'd0);
    chk("f84f0_no_err", 32'(err_cycles - err_base), 32'd0);

    // Consumer stalled: frame held stable until a single ready cycle.
    frame_ready = 1'b0;
    frame_start();
    send_bits(32'h0155, 16);
    nCS = 1'b1;
    tick(3);
    chk_frame("f0155_first", 1'b0, 7'h01, 8'h55);
    tick(20);
    chk_frame("f0155_held", 1'b0, 7'h01, 8'h55);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk("f0155_consumed", 32'(frame_valid), 32'd0);

    // Wrong bit counts pulse frame_err once; zero SCLKs stays silent.
    frame_ready = 1'b1;
    tick(2);
    err_base = err_cycles; valid_base = valid_cycles;
    frame_start();
    send_bits(32'h7FFF, 15);
    nCS = 1'b1;
    tick(8);
    chk("short_err_pulse", 32'(err_cycles - err_base), 32'd1);
    chk("short_no_valid", 32'(valid_cycles - valid_base), 32'd0);
    err_base = err_cycles;
    frame_start();
    send_bits(32'h1ABCD, 17);
    nCS = 1'b1;
    tick(8);
    chk("long_err_pulse", 32'(err_cycles - err_base), 32'd1);
    chk("long_no_valid", 32'(valid_cycles - valid_base), 32'd0);
    err_base = err_cycles;
    frame_start();
    tick(4);
    nCS = 1'b1;
    tick(8);
    chk("empty_no_err", 32'(err_cycles - err_base), 32'd0);
    chk("empty_no_valid", 32'(valid_cycles - valid_base), 32'd0);

    // Reload: A pending, ready on B's completion edge -> B shown, no overrun.
    frame_ready = 1'b0;
    frame_start();
    send_bits(32'h1234, 16);
    nCS = 1'b1;
    tick(3);
    chk_frame("fa_pending", 1'b0, 7'h12, 8'h34);
    frame_start();
    send_bits(32'hABCD, 16);
    nCS = 1'b1;
    tick(2);
    frame_ready = 1'b1;
    tick(1);
    frame_ready = 1'b0;
    chk_frame("fb_reload", 1'b1, 7'h2B, 8'hCD);
    chk("reload_no_overrun", 32'(overrun), 32'd0);

    // Overrun: B still pending with ready low, C completes -> dropped.
    frame_start();
    send_bits(32'h3C5A, 16);
    nCS = 1'b1;
    tick(4);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk_frame("overrun_holds_b", 1'b1, 7'h2B, 8'hCD);
    frame_ready = 1'b1;
    tick(1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    tick(2);

    // Reset mid-frame: remainder of that frame is ignored whole.
    err_base = err_cycles; valid_base = valid_cycles;
    frame_start();
    send_bits(32'h8A, 8);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    send_bits(32'hFF, 8);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    nCS = 1'b1;
    tick(8);
    chk("rst_mid_no_valid", 32'(valid_cycles - valid_base), 32'd0);
    chk("rst_mid_no_err", 32'(err_cycles - err_base), 32'd0);
    chk("rst_mid_overrun_clr", 32'(overrun), 32'd0);
    frame_start();
    send_bits(32'h8AFF, 16);
    nCS = 1'b1;
    tick(3);
    chk_frame("f8aff", 1'b1, 7'h0A, 8'hFF);
    tick(2);

    // SCLK rise in the same cycle as nCS rise after 16 bits is ignored.
    err_base = err_cycles;
    frame_start();
    send_bits(32'h3C5A, 16);
    COPI = 1'b1;
    SCLK = 1'b1;
    nCS  = 1'b1;
    tick(2);
    chk("coinc_edge2_valid", 32'(frame_valid), 32'd0);
    tick(1);
    chk_frame("coinc", 1'b0, 7'h3C, 8'h5A);
    SCLK = 1'b0;
    tick(4);
    chk("coinc_no_err", 32'(err_cycles - err_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
